// File: rtl/util_pkg.sv
// Shared helper functions used across FIFO and sequencing blocks.
package util_pkg;

  function automatic int clogb2(input int unsigned value);
    int unsigned v;
    int          r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/generic_sync_fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port.
// The array itself is never reset; only the read data register is.
module generic_sync_fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int SIZE       = 2048,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [SIZE];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/generic_sync_fifo_guarded.sv
// Synchronous FIFO with guarded access, threshold flags, peak tracking and
// sticky overflow/underflow; optional first-word-fall-through read.
module generic_sync_fifo_guarded
  import util_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int SIZE             = 2048,
  parameter int SHOW_AHEAD       = 0,
  parameter int ALMOST_EMPTY_THR = 10,
  parameter int ALMOST_FULL_THR  = SIZE - 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DATA_WIDTH-1:0]    d_i,
  input  logic                     we_i,
  input  logic                     rd_i,
  output logic [DATA_WIDTH-1:0]    q_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     almost_empty_o,
  output logic                     almost_full_o,
  output logic [clogb2(SIZE):0]    count_o,
  output logic [clogb2(SIZE):0]    peak_o,
  output logic                     overflow_o,
  output logic                     underflow_o,
  input  logic                     clr_err_i
);

  localparam int AW   = clogb2(SIZE);
  localparam int CW   = AW + 1;
  localparam bit FWFT = (SHOW_AHEAD != 0);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d, peak_q, peak_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  ready_q;
  logic                  byp_sel_q, byp_sel_d;
  logic [DATA_WIDTH-1:0] byp_q;
  logic                  empty, full, wr_acc, rd_acc, mem_re;
  logic [AW-1:0]         mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(SIZE));
    wr_acc   = ready_q & we_i & ~full;
    rd_acc   = ready_q & rd_i & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d = rd_ptr_q + AW'(rd_acc);

    count_d = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);

    // An error event in the same cycle as a clear wins.
    ovf_d = (ovf_q & ~clr_err_i) | (ready_q & we_i & full);
    unf_d = (unf_q & ~clr_err_i) | (ready_q & rd_i & empty);

    if (clr_err_i)             peak_d = count_d;
    else if (count_d > peak_q) peak_d = count_d;
    else                       peak_d = peak_q;

    // Show-ahead prefetches the next head every cycle; a write landing on
    // that head address this cycle is forwarded around the array.
    mem_re    = FWFT ? 1'b1 : rd_acc;
    mem_raddr = FWFT ? rd_ptr_d : rd_ptr_q;
    byp_sel_d = FWFT && wr_acc && (wr_ptr_q == rd_ptr_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      peak_q    <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      ready_q   <= 1'b0;
      byp_sel_q <= 1'b0;
      byp_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      peak_q    <= peak_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      ready_q   <= 1'b1;
      byp_sel_q <= byp_sel_d;
      if (byp_sel_d) byp_q <= d_i;
    end
  end

  generic_sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .SIZE      (SIZE),
    .ADDR_WIDTH(AW)
  ) u_mem (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (wr_acc),
    .waddr_i(wr_ptr_q),
    .wdata_i(d_i),
    .re_i   (mem_re),
    .raddr_i(mem_raddr),
    .rdata_o(mem_rdata)
  );

  assign q_o            = byp_sel_q ? byp_q : mem_rdata;
  assign empty_o        = empty;
  assign full_o         = full;
  assign almost_empty_o = (count_q <= CW'(ALMOST_EMPTY_THR));
  assign almost_full_o  = (count_q >= CW'(ALMOST_FULL_THR));
  assign count_o        = count_q;
  assign peak_o         = peak_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule

// File: tb/tb_generic_sync_fifo_guarded.sv
// Drives a registered-read and a show-ahead FIFO with identical stimulus and
// checks both against a queue-based reference model.
module tb_generic_sync_fifo_guarded;
  localparam int DW  = 16;
  localparam int SZ  = 16;
  localparam int AET = 2;
  localparam int AFT = 12;
  localparam int CW  = 5;

  logic          clk = 1'b0;
  logic          rst, we, rd, clr;
  logic [DW-1:0] d;

  logic [DW-1:0] q_a, q_b;
  logic          empty_a, full_a, ae_a, af_a, ovf_a, unf_a;
  logic          empty_b, full_b, ae_b, af_b, ovf_b, unf_b;
  logic [CW-1:0] cnt_a, peak_a, cnt_b, peak_b;

  always #5 clk = ~clk;

  generic_sync_fifo_guarded #(.DATA_WIDTH(DW), .SIZE(SZ), .SHOW_AHEAD(0),
    .ALMOST_EMPTY_THR(AET), .ALMOST_FULL_THR(AFT)) dut_a (
    .clk_i(clk), .rst_i(rst), .d_i(d), .we_i(we), .rd_i(rd), .q_o(q_a),
    .empty_o(empty_a), .full_o(full_a), .almost_empty_o(ae_a),
    .almost_full_o(af_a), .count_o(cnt_a), .peak_o(peak_a),
    .overflow_o(ovf_a), .underflow_o(unf_a), .clr_err_i(clr));

  generic_sync_fifo_guarded #(.DATA_WIDTH(DW), .SIZE(SZ), .SHOW_AHEAD(1),
    .ALMOST_EMPTY_THR(AET), .ALMOST_FULL_THR(AFT)) dut_b (
    .clk_i(clk), .rst_i(rst), .d_i(d), .we_i(we), .rd_i(rd), .q_o(q_b),
    .empty_o(empty_b), .full_o(full_b), .almost_empty_o(ae_b),
    .almost_full_o(af_b), .count_o(cnt_b), .peak_o(peak_b),
    .overflow_o(ovf_b), .underflow_o(unf_b), .clr_err_i(clr));

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue, plus last popped word and sticky state.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_q0;
  int            m_peak;
  bit            m_ovf, m_unf, m_ready;

  function automatic logic [CW-1:0] exp_cnt();
    return CW'(mq.size());
  endfunction

  function automatic logic [5:0] exp_flags();
    return {mq.size() == 0, mq.size() <= AET, mq.size() == SZ,
            mq.size() >= AFT, m_ovf, m_unf};
  endfunction

  task automatic m_reset();
    mq.delete();
    m_q0 = '0; m_peak = 0; m_ovf = 0; m_unf = 0; m_ready = 0;
  endtask

  task automatic m_step(input bit w, input bit r, input logic [DW-1:0] wd, input bit c);
    bit f, e;
    if (!m_ready) begin
      m_ready = 1;
      return;
    end
    f = (mq.size() == SZ);
    e = (mq.size() == 0);
    if (r && !e) m_q0 = mq.pop_front();
    if (w && !f) mq.push_back(wd);
    m_ovf  = (m_ovf && !c) || (w && f);
    m_unf  = (m_unf && !c) || (r && e);
    m_peak = c ? mq.size() : ((mq.size() > m_peak) ? mq.size() : m_peak);
  endtask

  task automatic cycle(input bit w, input bit r, input logic [DW-1:0] wd, input bit c);
    we = w; rd = r; d = wd; clr = c;
    @(posedge clk);
    m_step(w, r, wd, c);
    #1;
    we = 0; rd = 0; clr = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({empty_a, ae_a, full_a, af_a, ovf_a, unf_a} !== 6'b110000 ||
        {empty_b, ae_b, full_b, af_b, ovf_b, unf_b} !== 6'b110000) begin
      bad++;
      $display("FAIL reset_flags a=%b b=%b exp=110000",
               {empty_a, ae_a, full_a, af_a, ovf_a, unf_a},
               {empty_b, ae_b, full_b, af_b, ovf_b, unf_b});
    end
    total++;
    if (cnt_a !== '0 || cnt_b !== '0 || peak_a !== '0 || peak_b !== '0 ||
        q_a !== '0 || q_b !== '0) begin
      bad++;
      $display("FAIL reset_values cnt=%0d/%0d peak=%0d/%0d q=%h/%h exp all 0",
               cnt_a, cnt_b, peak_a, peak_b, q_a, q_b);
    end
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 0, 16'h1234, 0);
    total++;
    if (cnt_a !== '0 || empty_a !== 1'b1 || cnt_b !== '0) begin
      bad++;
      $display("FAIL first_edge_ignored cnt=%0d/%0d empty=%b exp cnt=0 empty=1",
               cnt_a, cnt_b, empty_a);
    end
  endtask

  task automatic test_fill_full();
    logic [DW-1:0] exp;
    for (int i = 0; i < SZ; i++) begin
      cycle(1, 0, DW'($urandom), 0);
      total++;
      if (cnt_a !== exp_cnt() || cnt_b !== exp_cnt()) begin
        bad++;
        $display("FAIL fill_count i=%0d got=%0d/%0d exp=%0d", i, cnt_a, cnt_b, exp_cnt());
      end
    end
    cycle(1, 0, 16'hDEAD, 0);
    total++;
    if (full_a !== 1'b1 || cnt_a !== CW'(16) || ovf_a !== 1'b1 || ovf_b !== 1'b1) begin
      bad++;
      $display("FAIL overflow_at_full full=%b cnt=%0d ovf=%b/%b exp full=1 cnt=16 ovf=1",
               full_a, cnt_a, ovf_a, ovf_b);
    end
    for (int i = 0; i < SZ; i++) begin
      exp = mq[0];
      total++;
      if (q_b !== exp) begin
        bad++;
        $display("FAIL fill_head_sa i=%0d got=%h exp=%h", i, q_b, exp);
      end
      cycle(0, 1, '0, 0);
      total++;
      if (q_a !== exp) begin
        bad++;
        $display("FAIL fill_readback i=%0d got=%h exp=%h", i, q_a, exp);
      end
    end
    total++;
    if (empty_a !== 1'b1 || empty_b !== 1'b1) begin
      bad++;
      $display("FAIL fill_drained empty=%b/%b exp=1", empty_a, empty_b);
    end
  endtask

  task automatic test_underflow();
    cycle(0, 1, '0, 0);
    total++;
    if (unf_a !== 1'b1 || unf_b !== 1'b1 || cnt_a !== '0 || q_a !== m_q0) begin
      bad++;
      $display("FAIL underflow unf=%b/%b cnt=%0d q=%h exp unf=1 cnt=0 q=%h",
               unf_a, unf_b, cnt_a, q_a, m_q0);
    end
    cycle(0, 0, '0, 1);
    total++;
    if (unf_a !== 1'b0 || ovf_a !== 1'b0 || unf_b !== 1'b0 || peak_a !== '0) begin
      bad++;
      $display("FAIL clear_err unf=%b/%b ovf=%b peak=%0d exp 0", unf_a, unf_b, ovf_a, peak_a);
    end
  endtask

  task automatic test_full_simul();
    logic [DW-1:0] exp;
    for (int i = 0; i < SZ; i++) cycle(1, 0, DW'($urandom), 0);
    exp = mq[0];
    cycle(1, 1, 16'hBEEF, 0);
    total++;
    if (cnt_a !== CW'(15) || ovf_a !== 1'b1 || full_a !== 1'b0 || q_a !== exp) begin
      bad++;
      $display("FAIL simul_at_full cnt=%0d ovf=%b full=%b q=%h exp cnt=15 ovf=1 full=0 q=%h",
               cnt_a, ovf_a, full_a, q_a, exp);
    end
    while (mq.size() > 0) begin
      exp = mq[0];
      cycle(0, 1, '0, 0);
      total++;
      if (q_a !== exp) begin
        bad++;
        $display("FAIL simul_drain got=%h exp=%h", q_a, exp);
      end
    end
    cycle(0, 0, '0, 1);
  endtask

  task automatic test_show_ahead();
    int n = 0;
    cycle(1, 0, 16'hA5A5, 0);
    while (!(q_b === 16'hA5A5 && empty_b === 1'b0) && n < 1) begin
      cycle(0, 0, '0, 0);
      n++;
    end
    total++;
    if (q_b !== 16'hA5A5 || empty_b !== 1'b0) begin
      bad++;
      $display("FAIL show_ahead_latency q=%h empty=%b exp q=a5a5 empty=0", q_b, empty_b);
    end
    total++;
    if (q_a !== m_q0) begin
      bad++;
      $display("FAIL registered_q_held got=%h exp=%h", q_a, m_q0);
    end
    cycle(0, 1, '0, 0);
    total++;
    if (q_a !== 16'hA5A5 || empty_b !== 1'b1) begin
      bad++;
      $display("FAIL show_ahead_pop q_a=%h empty_b=%b exp q=a5a5 empty=1", q_a, empty_b);
    end
  endtask

  task automatic test_thresholds_wrap();
    logic [DW-1:0] exp;
    cycle(0, 0, '0, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, DW'($urandom), 0);
      total++;
      if (af_a !== (mq.size() >= AFT) || ae_a !== (mq.size() <= AET) ||
          af_b !== af_a || ae_b !== ae_a) begin
        bad++;
        $display("FAIL ramp_flags cnt=%0d af=%b ae=%b", mq.size(), af_a, ae_a);
      end
    end
    for (int i = 0; i < 40; i++) begin
      exp = mq[0];
      cycle(1, 1, DW'($urandom), 0);
      total++;
      if (q_a !== exp || cnt_a !== CW'(8) || q_b !== mq[0]) begin
        bad++;
        $display("FAIL stream i=%0d q=%h cnt=%0d qb=%h exp q=%h cnt=8 qb=%h",
                 i, q_a, cnt_a, q_b, exp, mq[0]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, DW'($urandom), 0);
      total++;
      if (af_a !== (mq.size() >= AFT) || af_b !== (mq.size() >= AFT)) begin
        bad++;
        $display("FAIL almost_full cnt=%0d got=%b/%b", mq.size(), af_a, af_b);
      end
    end
    while (mq.size() > 0) begin
      exp = mq[0];
      cycle(0, 1, '0, 0);
      total++;
      if (q_a !== exp || ae_a !== (mq.size() <= AET) || ae_b !== (mq.size() <= AET)) begin
        bad++;
        $display("FAIL drain cnt=%0d q=%h ae=%b/%b exp q=%h", mq.size(), q_a, ae_a, ae_b, exp);
      end
    end
    total++;
    if (peak_a !== CW'(12) || peak_b !== CW'(12)) begin
      bad++;
      $display("FAIL peak got=%0d/%0d exp=12", peak_a, peak_b);
    end
  endtask

  task automatic test_random();
    int wb, rb;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        wb = $urandom_range(10, 90);
        rb = 100 - wb;
      end
      cycle($urandom_range(0, 99) < wb, $urandom_range(0, 99) < rb,
            DW'($urandom), $urandom_range(0, 15) == 0);
      total++;
      if (cnt_a !== exp_cnt() || peak_a !== CW'(m_peak) ||
          {empty_a, ae_a, full_a, af_a, ovf_a, unf_a} !== exp_flags()) begin
        bad++;
        $display("FAIL rand_a i=%0d cnt=%0d peak=%0d flags=%b exp cnt=%0d peak=%0d flags=%b",
                 i, cnt_a, peak_a, {empty_a, ae_a, full_a, af_a, ovf_a, unf_a},
                 exp_cnt(), m_peak, exp_flags());
      end
      total++;
      if (cnt_b !== exp_cnt() || peak_b !== CW'(m_peak) ||
          {empty_b, ae_b, full_b, af_b, ovf_b, unf_b} !== exp_flags()) begin
        bad++;
        $display("FAIL rand_b i=%0d cnt=%0d flags=%b exp cnt=%0d flags=%b",
                 i, cnt_b, {empty_b, ae_b, full_b, af_b, ovf_b, unf_b}, exp_cnt(), exp_flags());
      end
      total++;
      if (q_a !== m_q0 || (mq.size() > 0 && q_b !== mq[0])) begin
        bad++;
        $display("FAIL rand_q i=%0d q_a=%h exp=%h q_b=%h", i, q_a, m_q0, q_b);
      end
    end
  endtask

  task automatic test_reset_midstream();
    while (mq.size() > 0) cycle(0, 1, '0, 0);
    for (int i = 0; i < 9; i++) cycle(1, 0, DW'($urandom), 0);
    total++;
    if (cnt_a !== CW'(9)) begin
      bad++;
      $display("FAIL pre_reset_count got=%0d exp=9", cnt_a);
    end
    apply_reset();
    total++;
    if ({empty_a, ae_a, full_a, af_a, ovf_a, unf_a} !== 6'b110000 || cnt_a !== '0 ||
        peak_a !== '0 || q_a !== '0 || q_b !== '0 || cnt_b !== '0) begin
      bad++;
      $display("FAIL midstream_reset flags=%b cnt=%0d peak=%0d q=%h/%h exp 110000 0 0 0",
               {empty_a, ae_a, full_a, af_a, ovf_a, unf_a}, cnt_a, peak_a, q_a, q_b);
    end
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 0, '0, 0);
    cycle(1, 0, 16'h0001, 0);
    total++;
    if (q_b !== 16'h0001 || empty_b !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_head q=%h empty=%b exp q=0001 empty=0", q_b, empty_b);
    end
    cycle(0, 1, '0, 0);
    total++;
    if (q_a !== 16'h0001 || cnt_a !== '0) begin
      bad++;
      $display("FAIL post_reset_read q=%h cnt=%0d exp q=0001 cnt=0", q_a, cnt_a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; we = 0; rd = 0; clr = 0; d = '0;
    m_reset();
    test_reset();
    test_fill_full();
    test_underflow();
    test_full_simul();
    test_show_ahead();
    test_thresholds_wrap();
    test_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/generic_sync_fifo_guarded.md
GENERIC_SYNC_FIFO_GUARDED -- requirements
Module: generic_sync_fifo_guarded

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter SIZE, default 2048, depth in words; power of two, >= 4.
REQ-003 SHALL have parameter SHOW_AHEAD, default 0; 1 = first-word-fall-through, 0 = registered read.
REQ-004 SHALL have parameter ALMOST_EMPTY_THR, default 10, almost-empty threshold in words.
REQ-005 SHALL have parameter ALMOST_FULL_THR, default SIZE-10, almost-full threshold in words.
REQ-006 SHALL have ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- d_i  in  DATA_WIDTH  write data.
- we_i  in  1  write request.
- rd_i  in  1  read request.
- q_o  out  DATA_WIDTH  read data.
- empty_o, full_o  out  1  occupancy flags.
- almost_empty_o, almost_full_o  out  1  threshold flags.
- count_o  out  clogb2(SIZE)+1  current occupancy, 0..SIZE.
- peak_o  out  clogb2(SIZE)+1  highest occupancy since reset or clear.
- overflow_o, underflow_o  out  1  sticky error flags.
- clr_err_i  in  1  synchronous clear of overflow_o, underflow_o, peak_o.

Function
REQ-007 SHALL accept a write only when we_i=1 and full_o=0; the flag value before the clock edge applies.
REQ-008 SHALL accept a read only when rd_i=1 and empty_o=0; a same-cycle write does not make an empty FIFO readable.
REQ-009 SHALL set overflow_o on the cycle after a rejected write (we_i=1, full_o=1); it stays set until clr_err_i or reset.
REQ-010 SHALL set underflow_o on the cycle after a rejected read (rd_i=1, empty_o=1); it is sticky in the same way as overflow_o.
REQ-011 SHALL handle accepted reads and writes:
- accepted write only: count +1.
- accepted read only: count -1.
- both accepted in the same cycle: count unchanged.
- all flags and count_o update on the edge following the access.
REQ-012 SHALL use clogb2(SIZE)-bit read and write pointers that wrap modulo SIZE with no explicit wrap logic; full/empty derive from count, not from pointer equality.
REQ-013 SHALL drive full_o = (count==SIZE) and empty_o = (count==0).
REQ-014 SHALL drive almost_full_o = (count>=ALMOST_FULL_THR) and almost_empty_o = (count<=ALMOST_EMPTY_THR).
REQ-015 SHALL, with SHOW_AHEAD=0, present the popped word on q_o one cycle after read acceptance and hold q_o until the next accepted read.
REQ-016 SHALL, with SHOW_AHEAD=1, present the head word on q_o whenever empty_o=0; an accepted read advances q_o to the next word on the following edge.
REQ-017 SHALL, with SHOW_AHEAD=1, make a word written into an empty FIFO visible with empty_o=0 no later than 2 cycles after the write edge.
REQ-018 SHALL update peak_o to max(peak_o, next count) every cycle.
REQ-019 SHALL, on clr_err_i, reset peak_o to the current count; a same-cycle overflow or underflow event takes priority and leaves its flag set.

Reset
REQ-020 SHALL, while rst_i=1, immediately force:
- pointers, count_o and peak_o to 0.
- empty_o=1, almost_empty_o=1.
- full_o=0, almost_full_o=0.
- overflow_o=0, underflow_o=0.
- q_o to all zeros.
REQ-021 SHALL discard all stored data on reset asserted mid-operation; the first word written after deassertion is the first word read.
REQ-022 SHALL accept no read or write on the first clock edge after rst_i deasserts.

Structure
REQ-023 SHALL take clogb2 from the shared util_pkg; no block-local typedefs are needed.
REQ-024 SHALL place storage in one sub-module, generic_sync_fifo_mem: simple dual-port RAM, 1-cycle registered read, no reset on the array.

Verification
REQ-025 SHALL cover fill to full: SIZE=16, 16 writes then a 17th with we_i=1 -> full_o=1, count_o=16, overflow_o=1, and the 16 words read back in order.
REQ-026 SHALL cover drain past empty: read from an empty FIFO -> underflow_o=1, count_o=0, q_o unchanged; clr_err_i pulse -> underflow_o=0.
REQ-027 SHALL cover simultaneous access at full: SIZE=16, full FIFO, we_i=rd_i=1 -> read accepted, write rejected, count_o=15, overflow_o=1.
REQ-028 SHALL cover show-ahead latency: SHOW_AHEAD=1, single write 0xA5A5 into an empty FIFO -> q_o=0xA5A5 and empty_o=0 within 2 cycles, without rd_i.
REQ-029 SHALL cover thresholds and wrap-around: SIZE=16, ALMOST_FULL_THR=12, ALMOST_EMPTY_THR=2, with 40 words streamed continuously at count 8 ->
- almost flags toggle exactly at counts 12 and 2.
- data integrity holds across pointer wrap.
- peak_o=12.
REQ-030 SHALL cover reset mid-stream: rst_i asserted with count_o=9 -> all outputs at reset values without a clock edge; then write 0x0001 and read -> q_o=0x0001.
